// File: rtl/hca_pkg.sv
// hca_pkg: shared types and sizing helpers for the pipelined Han-Carlson adder
package hca_pkg;
  localparam bit OP_ADD = 1'b0;
  localparam bit OP_SUB = 1'b1;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic int hca_levels(input int width);
    return $clog2(width) + 1;
  endfunction
  function automatic int hca_lat(input int width, input int pipe_every);
    return (hca_levels(width) + pipe_every - 1) / pipe_every + 1;
  endfunction
  function automatic gp_t gp_comb(input gp_t h, input gp_t l);
    return '{g: h.g | (h.p & l.g), p: h.p & l.p};
  endfunction
endpackage

// File: rtl/hca_prefix_level.sv
// hca_prefix_level: one combinational Han-Carlson level, odd-position span or even fix-up
module hca_prefix_level import hca_pkg::*; #(
  parameter int WIDTH = 28,
  parameter int LEVEL_IDX = 0
) (
  input  gp_t [WIDTH-1:0] a,
  output gp_t [WIDTH-1:0] y
);
  localparam int LEVELS = hca_levels(WIDTH);
  localparam bit FIX = LEVEL_IDX == LEVELS - 1;
  localparam int SPAN = FIX ? 1 : 1 << LEVEL_IDX;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if ((FIX ? i % 2 == 0 : i % 2 == 1) && i >= SPAN) begin : g_op
      assign y[i] = gp_comb(a[i], a[i-SPAN]);
    end else begin : g_pass
      assign y[i] = a[i];
    end
  end
endmodule

// File: rtl/pipe_hca_adder.sv
// pipe_hca_adder: pipelined Han-Carlson adder/subtractor with valid/ready handshakes
module pipe_hca_adder import hca_pkg::*; #(
  parameter int WIDTH = 28,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LEVELS = hca_levels(WIDTH);
  localparam int LAT = hca_lat(WIDTH, PIPE_EVERY);
  localparam int NP = LAT - 1;
  gp_t [WIDTH-1:0] gp_in;
  gp_t [WIDTH-1:0] st_gp [NP];
  gp_t [WIDTH-1:0] lv [LEVELS];
  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] st_p0 [NP];
  logic [TAG_W-1:0] st_tag [NP];
  logic [NP-1:0] st_cin;
  logic [LAT-1:0] v, rdy;
  logic [WIDTH:0] c;
  logic chain;
  assign in_ready = rdy[0];
  assign out_valid = v[LAT-1];
  always_comb begin
    y_eff = in_sub == OP_SUB ? ~in_y : in_y;
    for (int i = 0; i < WIDTH; i++) gp_in[i] = '{g: in_x[i] & y_eff[i], p: in_x[i] ^ y_eff[i]};
  end
  // a stage can take new data when it is empty or its contents move on this cycle
  always_comb begin
    chain = out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      chain = !v[k] || chain;
      rdy[k] = chain;
    end
  end
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    gp_t [WIDTH-1:0] src;
    if (l % PIPE_EVERY == 0) begin : g_reg
      assign src = st_gp[l/PIPE_EVERY];
    end else begin : g_chain
      assign src = lv[l-1];
    end
    hca_prefix_level #(.WIDTH(WIDTH), .LEVEL_IDX(l)) u_lvl (.a(src), .y(lv[l]));
  end
  always_comb begin
    c[0] = st_cin[NP-1];
    for (int i = 1; i <= WIDTH; i++) c[i] = lv[LEVELS-1][i-1].g | (lv[LEVELS-1][i-1].p & st_cin[NP-1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
      out_tag <= '0;
    end else begin
      v <= (rdy & {v[LAT-2:0], in_valid}) | (~rdy & v);
      if (in_valid && rdy[0]) begin
        st_gp[0] <= gp_in;
        st_p0[0] <= in_x ^ y_eff;
        st_cin[0] <= in_sub == OP_ADD ? in_cin : 1'b1;
        st_tag[0] <= in_tag;
      end
      for (int k = 1; k < NP; k++)
        if (v[k-1] && rdy[k]) begin
          st_gp[k] <= lv[k*PIPE_EVERY-1];
          st_p0[k] <= st_p0[k-1];
          st_cin[k] <= st_cin[k-1];
          st_tag[k] <= st_tag[k-1];
        end
      if (v[NP-1] && rdy[LAT-1]) begin
        out_sum <= st_p0[NP-1] ^ c[WIDTH-1:0];
        out_cout <= c[WIDTH];
        out_ovf <= c[WIDTH] ^ c[WIDTH-1];
        out_tag <= st_tag[NP-1];
      end
    end
  end
endmodule

// File: tb/tb_pipe_hca_adder.sv
// tb_pipe_hca_adder: scoreboard bench for pipe_hca_adder at default parameters
module tb_pipe_hca_adder;
  localparam int W = 28, PE = 2, TW = 4;
  localparam int LAT = ($clog2(W) + 1 + PE - 1) / PE + 1;
  typedef struct packed {
    logic [TW-1:0] tag;
    logic ovf;
    logic cout;
    logic [W-1:0] sum;
  } res_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] in_x, in_y, out_sum;
  logic [TW-1:0] in_tag, out_tag;
  res_t sb[$];
  int acc_n[$];
  int checks = 0, failures = 0, n = 0, emits = 0, cnt = 0;
  logic acc_now = 1'b0, emit_now = 1'b0, rand_rdy = 1'b0, lat_chk = 1'b0;

  pipe_hca_adder #(.WIDTH(W), .PIPE_EVERY(PE), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                                 input logic sub, input logic [TW-1:0] tag);
    logic [W-1:0] yy;
    logic [W:0] f;
    yy = sub ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sub | cin};
    return '{tag: tag, ovf: (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]), cout: f[W], sum: f[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd();
    int k = $urandom_range(0, 7);
    logic [W-1:0] r = W'({$urandom, $urandom});
    return k == 0 ? {W{1'b1}} : k == 1 ? {1'b0, {(W-1){1'b1}}} : k == 2 ? {1'b1, {(W-1){1'b0}}} : k == 3 ? '0 : r;
  endfunction

  function automatic logic [63:0] dut_res();
    return 64'({out_tag, out_ovf, out_cout, out_sum});
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    res_t e;
    int a;
    if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
    @(negedge clk);
    acc_now = in_valid && in_ready && !rst;
    emit_now = out_valid && out_ready && !rst;
    if (emit_now) begin
      emits++;
      if (sb.size() == 0) chk("unexpected_out", 64'(out_valid), 64'(0));
      else begin
        e = sb.pop_front();
        a = acc_n.pop_front();
        chk("result", dut_res(), 64'(e));
        if (lat_chk) chk("latency", 64'(n - a), 64'(LAT));
      end
    end
    if (acc_now) begin
      sb.push_back(model(in_x, in_y, in_cin, in_sub, in_tag));
      acc_n.push_back(n);
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin, input logic sub,
                      input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_cin = cin;
    in_sub = sub;
    in_tag = tag;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (acc_now) return;
    end
    chk("accept_timeout", 64'(acc_now), 64'(1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_x = W'($urandom);
    in_y = W'($urandom);
  endtask

  task automatic set_op(input int i);
    in_x = rnd();
    in_y = rnd();
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
    in_tag = TW'(i);
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at tick %0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_cin = 1'b0;
    in_sub = 1'b0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_fields", dut_res(), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    lat_chk = 1'b1;
    send(28'hFFFFFFF, 28'h0000001, 1'b0, 1'b0, 4'd3);
    idle();
    drain();
    send(28'h7FFFFFF, 28'h0000001, 1'b0, 1'b0, 4'd1);
    send(28'h0000005, 28'h0000007, 1'b1, 1'b1, 4'd2);
    send(28'h0FFFFFF, 28'h0000000, 1'b1, 1'b0, 4'd4);
    send(28'h8000000, 28'h0000001, 1'b0, 1'b1, 4'd5);
    idle();
    drain();
    lat_chk = 1'b0;
    out_ready = 1'b0;
    cnt = 0;
    in_valid = 1'b1;
    set_op(0);
    repeat (8) begin
      tick();
      if (acc_now) begin
        cnt++;
        set_op(cnt);
      end
    end
    chk("capacity", 64'(cnt), 64'(LAT));
    chk("in_ready_full", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    emits = 0;
    repeat (6) begin
      tick();
      if (acc_now) begin
        cnt++;
        if (cnt == 6) in_valid = 1'b0;
        else set_op(cnt);
      end
    end
    chk("stream_no_gap", 64'(emits), 64'(6));
    drain();
    out_ready = 1'b0;
    send(28'h1234567, 28'h0ABCDEF, 1'b1, 1'b0, 4'd9);
    idle();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("hold_reach", 64'(out_valid), 64'(1));
    repeat (5) begin
      in_x = W'($urandom);
      in_y = W'($urandom);
      tick();
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", dut_res(), 64'(sb[0]));
    end
    out_ready = 1'b1;
    tick();
    chk("hold_released", 64'(sb.size()), 64'(0));
    lat_chk = 1'b1;
    send(rnd(), rnd(), 1'b0, 1'b0, 4'd10);
    send(rnd(), rnd(), 1'b1, 1'b0, 4'd11);
    send(rnd(), rnd(), 1'b0, 1'b1, 4'd12);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    acc_n.delete();
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    emits = 0;
    repeat (8) tick();
    chk("flush_no_stale", 64'(emits), 64'(0));
    send(28'h5555555, 28'h2AAAAAA, 1'b1, 1'b0, 4'd13);
    idle();
    drain();
    lat_chk = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
      send(rnd(), rnd(), 1'($urandom), 1'($urandom), TW'(i));
    end
    idle();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hca_adder.md
Name: pipe_hca_adder

Overview:
- Parametrised, pipelined Han-Carlson prefix adder/subtractor with valid/ready handshakes on input and output.
- Next generation of the team's fixed-width combinational Han-Carlson adders: generic WIDTH, configurable register insertion between prefix levels, per-transaction add/sub mode, carry-in, signed overflow flag and a sideband tag.
- Sits in datapath pipelines that need a timing-closable wide adder with backpressure.

Parameters:
- WIDTH, 28, operand/sum width; legal range 2..64.
- PIPE_EVERY, 2, prefix levels per register stage; legal range 1..LEVELS.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- LEVELS (derived, not overridable): ceil(log2(WIDTH)) + 1. This is the odd-position Kogge-Stone levels plus the final even-position fix-up level. For WIDTH=28, LEVELS=6.
- LAT (derived): ceil(LEVELS/PIPE_EVERY) + 1. For the defaults, LAT=4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept the operation this cycle.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y.
- in_cin  in  1  carry-in; used in add mode only.
- in_sub  in  1  0 = X+Y+cin; 1 = X-Y, computed as X+~Y+1 with cin ignored.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum or difference, modulo 2^WIDTH.
- out_cout  out  1  carry-out. In sub mode this is the not-borrow: 1 when X>=Y unsigned.
- out_ovf  out  1  two's-complement signed overflow.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Stage 0 register: captures G=X&Y', P=X^Y' and the effective cin, where Y'=~Y when in_sub=1 and cin_eff=in_sub ? 1 : in_cin. Also captures P0, the operand MSBs and the tag.
- Prefix stages:
  - Odd positions first: one adjacent-pair combine, then Kogge-Stone doubling spans among odd positions.
  - Last level: each even position i>0 combines with position i-1.
  - Carry operator: G = Gh | (Ph & Gl); P = Ph & Pl.
  - A pipeline register follows every PIPE_EVERY levels. If PIPE_EVERY does not divide LEVELS, the final stage holds the remainder.
- Sum logic:
  - c[i] = G[i-1] | (P[i-1] & cin_eff) for i>0; c[0] = cin_eff.
  - sum[i] = P0[i] ^ c[i].
  - out_cout = c[WIDTH].
  - out_ovf = c[WIDTH] ^ c[WIDTH-1].
  - The sum logic is registered into the output stage.
- Latency: an operation accepted at edge t presents out_valid at edge t+LAT, provided out_ready has been high throughout. Throughput is 1 op/cycle.
- Handshake:
  - Transfer occurs on valid&ready at either port.
  - out_valid/out_sum/out_cout/out_ovf/out_tag must stay stable while out_valid=1 and out_ready=0.
  - Each stage advances when its successor is empty or advancing; bubbles collapse.
  - in_ready = !stage0_valid || stage0_advance. This combinational path from out_ready is permitted.
- Capacity: LAT operations. With out_ready held low, in_ready deasserts after LAT accepts.
- Ordering: results emerge strictly in acceptance order, with no loss or duplication.
- Reset:
  - All stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_tag go to 0.
  - in_ready reads 1 in the first cycle after reset releases.
  - Reset mid-flight discards all in-flight operations, with no partial output.
- Simultaneous events:
  - Accept and emit in the same cycle at a full pipeline is legal and keeps occupancy constant.
  - in_valid with rst=1 is ignored.
- Operand values on in_x/in_y while in_valid=0 are don't-care and must not disturb stored data.

Decomposition:
- Package hca_pkg holds:
  - function hca_levels(width);
  - function hca_lat(width, pipe_every);
  - localparam OP_ADD=0, OP_SUB=1;
  - packed struct gp_t {g, p}.
- Sub-module hca_prefix_level:
  - Parameters WIDTH and LEVEL_IDX; one combinational prefix level, odd-span or even fix-up.
  - The top generates LEVELS instances and inserts registers per PIPE_EVERY.

Test Plan:
- Defaults, out_ready=1: X=0xFFFFFFF, Y=0x0000001, add, cin=0, tag=3 -> four cycles later: sum=0x0000000, cout=1, ovf=0, tag=3.
- X=0x7FFFFFF, Y=0x0000001, add -> sum=0x8000000, cout=0, ovf=1. Then X=0x0000005, Y=0x0000007, sub -> sum=0xFFFFFFE, cout=0, ovf=0.
- out_ready=0, six back-to-back ops (tags 0..5) -> in_ready low after four accepts. Release out_ready -> tags 0..5 out in order, with no gaps once streaming.
- Random out_ready toggling, 10k random ops, WIDTH in {2, 28, 33, 64}, PIPE_EVERY in {1, 2, LEVELS} -> every result matches a reference model, including cout/ovf.
- rst pulsed for one cycle with three ops in flight -> out_valid=0 the next cycle, no stale result ever emerges, and the next op after reset completes at t+LAT.
- Hold test: out_valid=1, out_ready=0 for 5 cycles while in_x/in_y toggle -> outputs stable, then the correct value transfers.
